// File: rtl/poly_sub_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// poly_sub_ctrl_pkg
// Shared constants, FSM state encoding and the modular-subtract helper used
// by the polynomial subtraction sequencer and its arithmetic lane.
//   DATA_WIDTH : coefficient width
//   Q          : modulus (Q < 2**DATA_WIDTH)
//   state_t    : controller states IDLE/READ/DRAIN/DONE
//   mod_sub    : (x - y) mod Q for operands already in [0,Q)
// ---------------------------------------------------------------------------
package poly_sub_ctrl_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int Q          = 12289;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One extra bit catches the borrow; adding Q back folds a negative
  // difference into [0,Q). The sum is deliberately truncated to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] mod_sub(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y
  );
    logic [DATA_WIDTH:0] diff;
    diff = {1'b0, x} - {1'b0, y};
    if (diff[DATA_WIDTH]) begin
      mod_sub = diff[DATA_WIDTH-1:0] + DATA_WIDTH'(Q);
    end else begin
      mod_sub = diff[DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/poly_sub_lane.sv
// ---------------------------------------------------------------------------
// poly_sub_lane
// One registered modular-subtract lane.
//   clk, rst_n : clock, synchronous active-low reset
//   op_valid   : operands valid this cycle
//   swap       : 0 -> res = a - b mod Q, 1 -> res = b - a mod Q
//   op_a, op_b : operands in [0,Q)
//   res_valid  : op_valid delayed by one cycle
//   res_data   : result register, holds its value when op_valid is low
// ---------------------------------------------------------------------------
module poly_sub_lane
  import poly_sub_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  swap,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data
);

  logic [DATA_WIDTH-1:0] x_s;
  logic [DATA_WIDTH-1:0] y_s;

  // Operand ordering for the two subtraction directions.
  always_comb begin
    x_s = op_a;
    y_s = op_b;
    if (swap) begin
      x_s = op_b;
      y_s = op_a;
    end else begin
      x_s = op_a;
      y_s = op_b;
    end
  end

  // Result and valid register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      res_valid <= op_valid;
      if (op_valid) begin
        res_data <= mod_sub(x_s, y_s);
      end else begin
        res_data <= res_data;
      end
    end
  end

endmodule

// File: rtl/poly_sub_ctrl.sv
// ---------------------------------------------------------------------------
// poly_sub_ctrl
// Sequencer for coefficient-wise modular subtraction dst = A - B (or B - A)
// over N coefficients read from two banks and written to a destination port.
//   clk, rst_n         : clock, synchronous active-low reset
//   start, mode        : run request (sampled in IDLE), direction latched on start
//   busy, done         : high in READ/DRAIN; one-cycle pulse after last write
//   rd_addr, rd_en     : shared read port to banks A and B
//   a_rdata, b_rdata   : bank data, RAM_LATENCY cycles after rd_en
//   wr_addr, wr_data,
//   wr_en              : destination write port
// ---------------------------------------------------------------------------
module poly_sub_ctrl
  import poly_sub_ctrl_pkg::*;
#(
  parameter int N           = 1024,
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en
);

  // Explicit terminal compare so N == 2**ADDR_WIDTH never relies on wrap.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] rd_cnt_r, rd_cnt_s;
  logic                  rd_en_r, rd_en_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  mode_r, mode_s;

  logic                  vld_pipe_r  [RAM_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_pipe_r [RAM_LATENCY];
  logic                  aligned_vld_s;
  logic [ADDR_WIDTH-1:0] aligned_addr_s;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // Next-state and next-output decode; outputs are registered with the state.
  always_comb begin
    state_s  = state_r;
    rd_cnt_s = rd_cnt_r;
    rd_en_s  = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    mode_s   = mode_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = READ;
          mode_s   = mode;
          rd_cnt_s = {ADDR_WIDTH{1'b0}};
          rd_en_s  = 1'b1;
          busy_s   = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      READ: begin
        busy_s = 1'b1;
        if (rd_cnt_r == LAST_ADDR) begin
          state_s = DRAIN;
        end else begin
          rd_cnt_s = rd_cnt_r + ADDR_WIDTH'(1);
          rd_en_s  = 1'b1;
        end
      end
      DRAIN: begin
        // Leave once the final write is on the destination port.
        if (wr_en_s && (wr_addr_r == LAST_ADDR)) begin
          state_s = DONE;
          done_s  = 1'b1;
        end else begin
          busy_s  = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Controller state and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rd_cnt_r <= {ADDR_WIDTH{1'b0}};
      rd_en_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mode_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      rd_cnt_r <= rd_cnt_s;
      rd_en_r  <= rd_en_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      mode_r   <= mode_s;
    end
  end

  // Delay the read valid/address so they line up with returned RAM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        vld_pipe_r[i]  <= 1'b0;
        addr_pipe_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      vld_pipe_r[0]  <= rd_en_r;
      addr_pipe_r[0] <= rd_cnt_r;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        addr_pipe_r[i] <= addr_pipe_r[i-1];
      end
    end
  end

  assign aligned_vld_s  = vld_pipe_r[RAM_LATENCY-1];
  assign aligned_addr_s = addr_pipe_r[RAM_LATENCY-1];

  // Write address tracks the lane's register stage and holds between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (aligned_vld_s) begin
      wr_addr_r <= aligned_addr_s;
    end else begin
      wr_addr_r <= wr_addr_r;
    end
  end

  poly_sub_lane u_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (aligned_vld_s),
    .swap      (mode_r),
    .op_a      (a_rdata),
    .op_b      (b_rdata),
    .res_valid (wr_en_s),
    .res_data  (wr_data_s)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_addr = rd_cnt_r;
  assign rd_en   = rd_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_s;
  assign wr_en   = wr_en_s;

endmodule

// File: tb/tb_poly_sub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_poly_sub_ctrl
// Two instances (RAM latency 1 and 3, N = 8 = 2**ADDR_WIDTH) driven by
// bank-memory models; observed writes are compared with a plain-arithmetic
// model of (x - y) mod Q and with the start-relative timing of each run.
// ---------------------------------------------------------------------------
module tb_poly_sub_ctrl;

  localparam int NN = 8;
  localparam int AW = 3;
  localparam int DW = 14;
  localparam int QQ = 12289;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start1 = 1'b0, mode1 = 1'b0, start3 = 1'b0, mode3 = 1'b0;
  logic busy1, done1, rd_en1, wr_en1, busy3, done3, rd_en3, wr_en3;
  logic [AW-1:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
  logic [DW-1:0] wr_data1, wr_data3, a1, b1, a3, b3;
  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];
  logic [DW-1:0] sa [3];
  logic [DW-1:0] sb [3];

  poly_sub_ctrl #(.N(NN), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_en(rd_en1), .a_rdata(a1), .b_rdata(b1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_en(wr_en1));

  poly_sub_ctrl #(.N(NN), .ADDR_WIDTH(AW), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .busy(busy3), .done(done3),
    .rd_addr(rd_addr3), .rd_en(rd_en3), .a_rdata(a3), .b_rdata(b3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_en(wr_en3));

  // Latency-1 bank model
  always @(posedge clk) begin
    if (rd_en1) begin
      a1 <= mem_a[rd_addr1];
      b1 <= mem_b[rd_addr1];
    end
  end

  // Latency-3 bank model
  always @(posedge clk) begin
    sa[0] <= rd_en3 ? mem_a[rd_addr3] : 14'd0;
    sb[0] <= rd_en3 ? mem_b[rd_addr3] : 14'd0;
    sa[1] <= sa[0]; sb[1] <= sb[0];
    sa[2] <= sa[1]; sb[2] <= sb[1];
  end
  assign a3 = sa[2];
  assign b3 = sb[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int sel = 1;
  int wr_a[$], wr_d[$], wr_c[$], done_c[$], busy_c[$], re_c[$];

  // Monitor of the selected instance, sampled on the falling edge
  always @(negedge clk) begin
    if (sel == 1) begin
      if (wr_en1) begin wr_a.push_back(int'(wr_addr1)); wr_d.push_back(int'(wr_data1)); wr_c.push_back(cyc); end
      if (done1) done_c.push_back(cyc);
      if (busy1) busy_c.push_back(cyc);
      if (rd_en1) re_c.push_back(cyc);
    end else begin
      if (wr_en3) begin wr_a.push_back(int'(wr_addr3)); wr_d.push_back(int'(wr_data3)); wr_c.push_back(cyc); end
      if (done3) done_c.push_back(cyc);
      if (busy3) busy_c.push_back(cyc);
      if (rd_en3) re_c.push_back(cyc);
    end
  end

  function automatic int ref_sub(input int a, input int b, input bit m);
    int x, y;
    x = m ? b : a;
    y = m ? a : b;
    return ((x - y) % QQ + QQ) % QQ;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    done_c.delete(); busy_c.delete(); re_c.delete();
  endtask

  task automatic fill_random();
    for (int k = 0; k < NN; k++) begin
      mem_a[k] = DW'($urandom_range(0, QQ - 1));
      mem_b[k] = DW'($urandom_range(0, QQ - 1));
    end
  endtask

  // Drive one run on instance s and collect its activity until done (bounded).
  task automatic run_capture(input int s, input logic m, input bit toggle, input bit extra_start,
                             output int p, output bit timeout);
    sel = s;
    clear_logs();
    step();
    if (s == 1) begin start1 = 1'b1; mode1 = m; end else begin start3 = 1'b1; mode3 = m; end
    p = cyc;
    step();
    start1 = 1'b0; start3 = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done_c.size() > 0) begin timeout = 1'b0; break; end
      if (toggle) begin mode1 = ~mode1; mode3 = ~mode3; end
      if (extra_start && i == 4) begin
        if (s == 1) start1 = 1'b1; else start3 = 1'b1;
      end else begin
        start1 = 1'b0; start3 = 1'b0;
      end
      step();
    end
    start1 = 1'b0; start3 = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if ({busy1, done1, rd_en1, wr_en1} !== 4'b0000) begin bad++; $display("FAIL reset_ctl1: got %b want 0000", {busy1, done1, rd_en1, wr_en1}); end
    total++; if ({busy3, done3, rd_en3, wr_en3} !== 4'b0000) begin bad++; $display("FAIL reset_ctl3: got %b want 0000", {busy3, done3, rd_en3, wr_en3}); end
    total++; if ({rd_addr1, wr_addr1, wr_data1} !== 20'd0) begin bad++; $display("FAIL reset_data1: got %h want 0", {rd_addr1, wr_addr1, wr_data1}); end
    total++; if ({rd_addr3, wr_addr3, wr_data3} !== 20'd0) begin bad++; $display("FAIL reset_data3: got %h want 0", {rd_addr3, wr_addr3, wr_data3}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int p; bit to;
    for (int k = 0; k < NN; k++) begin mem_a[k] = DW'(k + 10); mem_b[k] = DW'(k); end
    run_capture(1, 1'b0, 1'b0, 1'b0, p, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
    total++; if (wr_c.size() != NN) begin bad++; $display("FAIL basic_nwr: got %0d want %0d", wr_c.size(), NN); end
    total++; if (re_c.size() != NN) begin bad++; $display("FAIL basic_nrd: got %0d want %0d", re_c.size(), NN); end
    for (int k = 0; k < wr_c.size() && k < NN; k++) begin
      total++; if (wr_d[k] != 10) begin bad++; $display("FAIL basic_data[%0d]: got %0d want 10", k, wr_d[k]); end
      total++; if (wr_a[k] != k) begin bad++; $display("FAIL basic_addr[%0d]: got %0d want %0d", k, wr_a[k], k); end
      total++; if (wr_c[k] != p + 3 + k) begin bad++; $display("FAIL basic_wcyc[%0d]: got %0d want %0d", k, wr_c[k] - p, 3 + k); end
    end
    total++; if (done_c.size() != 1 || done_c[0] != p + 11) begin bad++; $display("FAIL basic_done: got n=%0d want at +11", done_c.size()); end
    total++; if (busy_c.size() != 10 || busy_c[0] != p + 1 || busy_c[$] != p + 10) begin bad++; $display("FAIL basic_busy: got n=%0d want 10 cycles +1..+10", busy_c.size()); end
  endtask

  task automatic test_boundary();
    int pa[5] = '{5, 0, 12288, 0, 0};
    int pb[5] = '{7, 0, 0, 12288, 1};
    int e0[5] = '{12287, 0, 12288, 1, 12288};
    int e1[5] = '{2, 0, 1, 12288, 1};
    int p; bit to;
    fill_random();
    for (int k = 0; k < 5; k++) begin mem_a[k] = DW'(pa[k]); mem_b[k] = DW'(pb[k]); end
    for (int m = 0; m < 2; m++) begin
      // second pass also flips mode every busy cycle
      run_capture(1, m[0], m == 1, 1'b0, p, to);
      mode1 = 1'b0;
      total++; if (to || wr_d.size() != NN) begin bad++; $display("FAIL bnd%0d_count: got %0d want %0d", m, wr_d.size(), NN); end
      for (int k = 0; k < wr_d.size() && k < NN; k++) begin
        int e;
        e = (k < 5) ? ((m == 0) ? e0[k] : e1[k]) : ref_sub(int'(mem_a[k]), int'(mem_b[k]), m[0]);
        total++; if (wr_d[k] != e) begin bad++; $display("FAIL bnd%0d_data[%0d]: got %0d want %0d", m, k, wr_d[k], e); end
      end
    end
  endtask

  task automatic test_random();
    int p, lat; bit to, m;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      m = 1'($urandom_range(0, 1));
      lat = (it % 2 == 0) ? 1 : 3;
      run_capture((lat == 1) ? 1 : 3, m, 1'($urandom_range(0, 1)), 1'b0, p, to);
      mode1 = 1'b0; mode3 = 1'b0;
      total++; if (to || wr_d.size() != NN) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, wr_d.size(), NN); end
      for (int k = 0; k < wr_d.size() && k < NN; k++) begin
        total++;
        if (wr_d[k] != ref_sub(int'(mem_a[k]), int'(mem_b[k]), m) || wr_a[k] != k || wr_c[k] != p + lat + 2 + k) begin
          bad++; $display("FAIL rnd%0d_wr[%0d]: got a=%0d d=%0d t=%0d want a=%0d d=%0d t=%0d", it, k, wr_a[k], wr_d[k], wr_c[k] - p,
                          k, ref_sub(int'(mem_a[k]), int'(mem_b[k]), m), lat + 2 + k);
        end
      end
      total++; if (done_c.size() != 1 || done_c[0] != p + NN + lat + 2) begin bad++; $display("FAIL rnd%0d_done: got n=%0d want at +%0d", it, done_c.size(), NN + lat + 2); end
    end
  endtask

  task automatic test_lat3();
    int p; bit to;
    fill_random();
    run_capture(3, 1'b0, 1'b0, 1'b1, p, to);
    total++; if (to || wr_a.size() != NN) begin bad++; $display("FAIL lat3_count: got %0d want %0d", wr_a.size(), NN); end
    for (int k = 0; k < wr_a.size() && k < NN; k++) begin
      total++;
      if (wr_a[k] != k || wr_d[k] != ref_sub(int'(mem_a[k]), int'(mem_b[k]), 1'b0) || wr_c[k] != p + 5 + k) begin
        bad++; $display("FAIL lat3_wr[%0d]: got a=%0d d=%0d t=%0d want a=%0d t=%0d", k, wr_a[k], wr_d[k], wr_c[k] - p, k, 5 + k);
      end
    end
    total++; if (done_c.size() != 1 || done_c[0] != p + 13) begin bad++; $display("FAIL lat3_done: got n=%0d want one at +13", done_c.size()); end
    total++; if (busy_c.size() != 12 || busy_c[0] != p + 1 || busy_c[$] != p + 12) begin bad++; $display("FAIL lat3_busy: got n=%0d want 12", busy_c.size()); end
    total++; if (re_c.size() != NN) begin bad++; $display("FAIL lat3_nrd: got %0d want %0d", re_c.size(), NN); end
  endtask

  task automatic test_reset_mid();
    int p; bit to;
    fill_random();
    sel = 1;
    clear_logs();
    step();
    start1 = 1'b1; mode1 = 1'b0;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 50 && wr_c.size() < 4; i++) step();
    total++; if (wr_c.size() != 4) begin bad++; $display("FAIL rmid_reach: got %0d writes want 4", wr_c.size()); end
    rst_n = 1'b0;
    step();
    total++; if (busy1 !== 1'b0 || wr_en1 !== 1'b0) begin bad++; $display("FAIL rmid_abort: got busy=%b wr_en=%b want 0 0", busy1, wr_en1); end
    rst_n = 1'b1;
    repeat (20) step();
    total++; if (done_c.size() != 0 || wr_c.size() != 4) begin bad++; $display("FAIL rmid_quiet: got done=%0d wr=%0d want 0 4", done_c.size(), wr_c.size()); end
    run_capture(1, 1'b1, 1'b0, 1'b0, p, to);
    total++; if (to || wr_d.size() != NN || done_c[0] != p + 11) begin bad++; $display("FAIL rmid_rerun: got wr=%0d want %0d", wr_d.size(), NN); end
    for (int k = 0; k < wr_d.size() && k < NN; k++) begin
      total++; if (wr_d[k] != ref_sub(int'(mem_a[k]), int'(mem_b[k]), 1'b1)) begin bad++; $display("FAIL rmid_data[%0d]: got %0d want %0d", k, wr_d[k], ref_sub(int'(mem_a[k]), int'(mem_b[k]), 1'b1)); end
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2;
    fill_random();
    sel = 1;
    clear_logs();
    step();
    start1 = 1'b1; mode1 = 1'b0; p1 = cyc;
    step();
    start1 = 1'b0;
    for (int i = 0; i < 100 && done_c.size() < 1; i++) step();
    start1 = 1'b1;       // DONE cycle: must be ignored
    step();
    p2 = cyc;            // following IDLE cycle: accepted
    step();
    start1 = 1'b0;
    for (int i = 0; i < 100 && done_c.size() < 2; i++) step();
    repeat (6) step();
    total++; if (done_c.size() != 2) begin bad++; $display("FAIL b2b_ndone: got %0d want 2", done_c.size()); end
    else begin
      total++; if (done_c[0] != p1 + 11) begin bad++; $display("FAIL b2b_done0: got +%0d want +11", done_c[0] - p1); end
      total++; if (done_c[1] != p2 + 11) begin bad++; $display("FAIL b2b_done1: got +%0d want +11", done_c[1] - p2); end
    end
    total++; if (wr_c.size() != 2 * NN) begin bad++; $display("FAIL b2b_nwr: got %0d want %0d", wr_c.size(), 2 * NN); end
    for (int k = 0; k < NN && NN + k < wr_c.size(); k++) begin
      total++;
      if (wr_a[NN + k] != k || wr_c[NN + k] != p2 + 3 + k || wr_d[NN + k] != ref_sub(int'(mem_a[k]), int'(mem_b[k]), 1'b0)) begin
        bad++; $display("FAIL b2b_wr[%0d]: got a=%0d t=+%0d d=%0d want a=%0d t=+%0d", k, wr_a[NN + k], wr_c[NN + k] - p2, wr_d[NN + k], k, 3 + k);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NN; k++) begin mem_a[k] = 14'd0; mem_b[k] = 14'd0; end
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_lat3();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_sub_ctrl.md
Name: poly_sub_ctrl

Overview:
- Sequencer for coefficient-wise modular subtraction of two polynomials held in separate coefficient RAMs (bank A, bank B); result written to a destination RAM port.
- Sits beside the NTT core and is started by the top-level controller between NTT/INTT passes.
- Contains one pipelined modular-subtract lane, an address counter, a read-latency delay line and a start/done handshake.

Parameters:
- DATA_WIDTH, 14, coefficient width
- Q, 12289, modulus; must satisfy Q < 2**DATA_WIDTH
- N, 1024, coefficients per polynomial
- ADDR_WIDTH, 10, address width; N <= 2**ADDR_WIDTH
- RAM_LATENCY, 1, read latency in cycles from address to data for both banks (1..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- mode  in  1  0: dst = A-B mod Q; 1: dst = B-A mod Q; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- rd_addr  out  ADDR_WIDTH  shared read address to banks A and B
- rd_en  out  1  read enable to both banks
- a_rdata  in  DATA_WIDTH  bank A read data, valid RAM_LATENCY cycles after rd_en
- b_rdata  in  DATA_WIDTH  bank B read data, same timing
- wr_addr  out  ADDR_WIDTH  destination write address
- wr_data  out  DATA_WIDTH  destination write data
- wr_en  out  1  destination write strobe

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, rd_en and wr_en = 0; rd_addr, wr_addr and wr_data = 0; valid and address delay lines cleared. A reset mid-operation aborts immediately. No further writes occur; destination contents are partial.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 -> READ; latch mode; rd_cnt=0. start in any other state is ignored.
  - READ: rd_en=1, rd_addr=rd_cnt, rd_cnt increments each cycle. After issuing address N-1, go to DRAIN.
  - DRAIN: rd_en=0. Wait until the write for address N-1 has been issued, then go to DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in READ and DRAIN, 0 in IDLE and DONE.
- Pipeline:
  - The read address and a valid bit are delayed RAM_LATENCY cycles to align with the returned data.
  - The aligned operands go through the subtract lane, which has one register stage.
  - A write for address k is issued (wr_en=1) exactly RAM_LATENCY+1 cycles after rd_addr=k is issued.
  - Writes are back-to-back with no bubbles.
- Latency: from the start cycle, the first write occurs at cycle 1+RAM_LATENCY+1. done is asserted 1 cycle after the last write. Total: start to done = N+RAM_LATENCY+2 cycles.
- Arithmetic:
  - x = mode ? b : a, y = mode ? a : b.
  - {borrow,d} = x - y at DATA_WIDTH+1 bits; result = borrow ? d+Q : d, truncated to DATA_WIDTH.
  - Operands are in [0,Q) by contract; the result is in [0,Q). Out-of-range operands produce an unspecified value but have no timing effect.
- Wrap-around:
  - rd_cnt stops at N-1 and never wraps into a second pass.
  - When N = 2**ADDR_WIDTH, the terminal condition uses the explicit compare rd_cnt==N-1, not overflow.
- wr_data and wr_addr hold their last value when wr_en=0.
- mode changes during busy have no effect.
- Back-to-back runs: start asserted in the DONE cycle is ignored. start in the following IDLE cycle is accepted.

Decomposition:
- Shared package (or header):
  - Q
  - DATA_WIDTH
  - state encodings IDLE=2'd0, READ=2'd1, DRAIN=2'd2, DONE=2'd3
- Sub-module poly_sub_lane:
  - Registered modular subtract of DATA_WIDTH-bit operands with an operand-swap input and a valid in/out.
  - Instantiated once.
- Controller FSM, counter and delay lines live in poly_sub_ctrl.

Test Plan:
- N=8, RAM_LATENCY=1, mode=0, A[k]=k+10, B[k]=k -> dst[k]=10 for all k; first wr_en 3 cycles after start; done 11 cycles after start; exactly 8 write strobes.
- Borrow/boundary, mode=0, pairs (A,B)=(5,7),(0,0),(12288,0),(0,12288),(0,1) -> 12287, 0, 12288, 1, 12288.
- mode=1 with the same pairs -> 2, 0, 1, 12288, 1. Also toggle mode while busy -> results unaffected.
- RAM_LATENCY=3, N=8 -> writes aligned to addresses 0..7 in order; done 13 cycles after start; a start pulse during busy is ignored (no restart, busy stays high continuously).
- Reset mid-run: pull rst_n low during the 4th write cycle -> next cycle busy=0, wr_en=0, done never pulses. A fresh start then completes normally.
- Back-to-back: start in the DONE cycle ignored; start one cycle later accepted -> second run completes with identical timing; N=2**ADDR_WIDTH (ADDR_WIDTH=3, N=8) terminates correctly without a second pass.
